btb_update_ctrl: RTL and testbench

Sequencer and filter for BTB writes. It accepts branch-resolution events from the EX stage over a valid/ready handshake and keeps only those that need a BTB write. Qualifying events are buffered in a small FIFO and drained one write per cycle onto the BTB update port (update_en / pc_update / target_addr_update). On a flush request it clears the FIFO and runs an invalidate sweep that rewrites every BTB entry to its reset state (tag 0, target 0).

---
 rtl/btb_update_ctrl.sv | 121 ++++++++++++
 tb/tb_btb_update_ctrl.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/btb_update_ctrl.sv
// Filters EX branch-resolution events down to those that need a BTB write, buffers
// them in a small FIFO, drains one write per cycle and runs a full-table invalidate sweep on flush.
module btb_update_ctrl #(
    parameter int SIZE       = 64,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_BITS   = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ex_valid,
    output logic                ex_ready,
    input  logic [31:0]         ex_pc,
    input  logic [31:0]         ex_target,
    input  logic                ex_taken,
    input  logic                ex_pred_hit,
    input  logic [31:0]         ex_pred_target,
    input  logic                flush_req,
    output logic                flush_busy,
    output logic                btb_update_en,
    output logic [31:0]         btb_pc_update,
    output logic [31:0]         btb_target_update,
    output logic [CNT_BITS-1:0] stat_wr_cnt
);
    localparam int IDX_BITS = $clog2(SIZE);
    localparam int PTR_BITS = $clog2(FIFO_DEPTH);

    typedef enum logic {
        NORMAL = 1'b0,
        SWEEP  = 1'b1
    } state_t;

    state_t                state_q;
    logic [IDX_BITS-1:0]   sweep_idx_q;
    logic [PTR_BITS:0]     wr_ptr_q;
    logic [PTR_BITS:0]     rd_ptr_q;
    logic                  en_q;
    logic [31:0]           pc_q;
    logic [31:0]           tgt_q;
    logic [CNT_BITS-1:0]   cnt_q;

    logic [31:0]           pc_mem  [FIFO_DEPTH];
    logic [31:0]           tgt_mem [FIFO_DEPTH];

    logic fifo_empty;
    logic fifo_full;
    logic qualify;
    logic push;
    logic pop;

    // The extra pointer bit distinguishes a full FIFO from an empty one.
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PTR_BITS] != rd_ptr_q[PTR_BITS]) &&
                        (wr_ptr_q[PTR_BITS-1:0] == rd_ptr_q[PTR_BITS-1:0]);

    assign ex_ready = (state_q == NORMAL) && !flush_req && !fifo_full;
    assign qualify  = ex_taken && (!ex_pred_hit || (ex_pred_target != ex_target));
    assign push     = ex_valid && ex_ready && qualify;
    assign pop      = (state_q == NORMAL) && !flush_req && !fifo_empty;

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr_q[PTR_BITS-1:0]]  <= ex_pc;
            tgt_mem[wr_ptr_q[PTR_BITS-1:0]] <= ex_target;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= NORMAL;
            sweep_idx_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            en_q        <= 1'b0;
            pc_q        <= '0;
            tgt_q       <= '0;
            cnt_q       <= '0;
        end else begin
            case (state_q)
                NORMAL: begin
                    if (flush_req) begin
                        // Pending updates are stale once the whole table is invalidated.
                        state_q     <= SWEEP;
                        sweep_idx_q <= '0;
                        wr_ptr_q    <= '0;
                        rd_ptr_q    <= '0;
                        en_q        <= 1'b0;
                    end else begin
                        if (push) begin
                            wr_ptr_q <= wr_ptr_q + (PTR_BITS+1)'(1);
                        end
                        if (pop) begin
                            rd_ptr_q <= rd_ptr_q + (PTR_BITS+1)'(1);
                            en_q     <= 1'b1;
                            pc_q     <= pc_mem[rd_ptr_q[PTR_BITS-1:0]];
                            tgt_q    <= tgt_mem[rd_ptr_q[PTR_BITS-1:0]];
                            cnt_q    <= cnt_q + CNT_BITS'(1);
                        end else begin
                            en_q <= 1'b0;
                        end
                    end
                end
                SWEEP: begin
                    en_q        <= 1'b1;
                    pc_q        <= {{(30-IDX_BITS){1'b0}}, sweep_idx_q, 2'b00};
                    tgt_q       <= '0;
                    sweep_idx_q <= sweep_idx_q + IDX_BITS'(1);
                    if (sweep_idx_q == IDX_BITS'(SIZE-1)) begin
                        state_q <= NORMAL;
                    end
                end
                default: state_q <= NORMAL;
            endcase
        end
    end

    assign flush_busy        = (state_q == SWEEP);
    assign btb_update_en     = en_q;
    assign btb_pc_update     = pc_q;
    assign btb_target_update = tgt_q;
    assign stat_wr_cnt       = cnt_q;
endmodule

// File: tb/tb_btb_update_ctrl.sv
// Bench for btb_update_ctrl: directed scenarios plus randomized traffic against a queue-based model.
module tb_btb_update_ctrl;
    localparam int SIZE     = 64;
    localparam int DEPTH    = 4;
    localparam int CNT_BITS = 16;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                ex_valid = 1'b0;
    logic                ex_ready;
    logic [31:0]         ex_pc = '0;
    logic [31:0]         ex_target = '0;
    logic                ex_taken = 1'b0;
    logic                ex_pred_hit = 1'b0;
    logic [31:0]         ex_pred_target = '0;
    logic                flush_req = 1'b0;
    logic                flush_busy;
    logic                btb_update_en;
    logic [31:0]         btb_pc_update;
    logic [31:0]         btb_target_update;
    logic [CNT_BITS-1:0] stat_wr_cnt;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    btb_update_ctrl #(.SIZE(SIZE), .FIFO_DEPTH(DEPTH), .CNT_BITS(CNT_BITS)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_pc(ex_pc), .ex_target(ex_target), .ex_taken(ex_taken),
        .ex_pred_hit(ex_pred_hit), .ex_pred_target(ex_pred_target),
        .flush_req(flush_req), .flush_busy(flush_busy),
        .btb_update_en(btb_update_en), .btb_pc_update(btb_pc_update),
        .btb_target_update(btb_target_update), .stat_wr_cnt(stat_wr_cnt)
    );

    // Reference model: a queue of pending {pc,target} writes plus sweep bookkeeping.
    bit [63:0]         m_q[$];
    bit                m_sweep = 1'b0;
    bit [31:0]         m_idx = '0;
    bit                m_en = 1'b0;
    bit [31:0]         m_pc = '0;
    bit [31:0]         m_tgt = '0;
    bit [CNT_BITS-1:0] m_cnt = '0;

    function automatic bit m_ready();
        return !m_sweep && !flush_req && (m_q.size() < DEPTH);
    endfunction

    function automatic bit qual(bit taken, bit hit, bit [31:0] pt, bit [31:0] t);
        return taken && (!hit || pt != t);
    endfunction

    always @(posedge clk or posedge rst) begin : model
        bit acc;
        if (rst) begin
            m_q.delete();
            m_sweep <= 1'b0;
            m_idx   <= '0;
            m_en    <= 1'b0;
            m_pc    <= '0;
            m_tgt   <= '0;
            m_cnt   <= '0;
        end else if (m_sweep) begin
            m_en  <= 1'b1;
            m_pc  <= m_idx * 4;
            m_tgt <= '0;
            m_idx <= m_idx + 1;
            if (m_idx == SIZE - 1) m_sweep <= 1'b0;
        end else if (flush_req) begin
            m_q.delete();
            m_sweep <= 1'b1;
            m_idx   <= '0;
            m_en    <= 1'b0;
        end else begin
            acc = ex_valid && m_ready();
            if (m_q.size() > 0) begin
                m_en  <= 1'b1;
                m_pc  <= m_q[0][63:32];
                m_tgt <= m_q[0][31:0];
                m_cnt <= m_cnt + 1'b1;
                void'(m_q.pop_front());
            end else begin
                m_en <= 1'b0;
            end
            if (acc && qual(ex_taken, ex_pred_hit, ex_pred_target, ex_target))
                m_q.push_back({ex_pc, ex_target});
        end
    end

    task automatic drive_ev(bit v, bit [31:0] pc, bit [31:0] tgt, bit tk, bit hit, bit [31:0] pt);
        ex_valid = v; ex_pc = pc; ex_target = tgt;
        ex_taken = tk; ex_pred_hit = hit; ex_pred_target = pt;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive_ev(0, 0, 0, 0, 0, 0);
        flush_req = 1'b0;
        #12;
        tests++;
        if ({btb_update_en, btb_pc_update, btb_target_update, stat_wr_cnt, flush_busy} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: en=%0b pc=%h tgt=%h cnt=%0d busy=%0b, required all 0",
                     btb_update_en, btb_pc_update, btb_target_update, stat_wr_cnt, flush_busy);
        end
        @(posedge clk); #1 rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            tests++;
            if (btb_update_en !== 1'b0 || stat_wr_cnt !== '0 || ex_ready !== 1'b1 || flush_busy !== 1'b0) begin
                fails++;
                $display("FAIL idle_cycle%0d: en=%0b cnt=%0d ready=%0b busy=%0b, required 0/0/1/0",
                         c, btb_update_en, stat_wr_cnt, ex_ready, flush_busy);
            end
        end
        $display("[TB] test_reset done");
    endtask

    task automatic test_single();
        @(posedge clk); #1 drive_ev(1, 32'h0000_1040, 32'h0000_2000, 1, 0, 0);
        @(negedge clk);
        tests++;
        if (ex_ready !== 1'b1) begin
            fails++; $display("FAIL single_ready: got %0b, required 1", ex_ready);
        end
        @(posedge clk); #1 ex_valid = 1'b0;
        @(negedge clk);
        tests++;
        if (btb_update_en !== 1'b0) begin
            fails++; $display("FAIL single_t1_en: got %0b, required 0", btb_update_en);
        end
        @(negedge clk);
        tests++;
        if (btb_update_en !== 1'b1 || btb_pc_update !== 32'h0000_1040 ||
            btb_target_update !== 32'h0000_2000 || stat_wr_cnt !== 16'd1) begin
            fails++;
            $display("FAIL single_t2_write: en=%0b pc=%h tgt=%h cnt=%0d, required 1/00001040/00002000/1",
                     btb_update_en, btb_pc_update, btb_target_update, stat_wr_cnt);
        end
        @(negedge clk);
        tests++;
        if (btb_update_en !== 1'b0) begin
            fails++; $display("FAIL single_t3_en: got %0b, required 0", btb_update_en);
        end
        $display("[TB] test_single done");
    endtask

    task automatic test_filter();
        bit [31:0] wpc[$];
        bit [31:0] wtg[$];
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            case (i)
                0: drive_ev(1, 32'h100, 32'h180, 0, 0, 0);
                1: drive_ev(1, 32'h104, 32'h180, 1, 1, 32'h180);
                2: drive_ev(1, 32'h108, 32'h200, 1, 1, 32'h100);
                default: drive_ev(1, 32'h10C, 32'h300, 1, 0, 0);
            endcase
            @(negedge clk);
            if (btb_update_en) begin wpc.push_back(btb_pc_update); wtg.push_back(btb_target_update); end
        end
        @(posedge clk); #1 ex_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (btb_update_en) begin wpc.push_back(btb_pc_update); wtg.push_back(btb_target_update); end
        end
        tests++;
        if (wpc.size() != 2) begin
            fails++; $display("FAIL filter_count: got %0d writes, required 2", wpc.size());
        end else begin
            tests++;
            if (wpc[0] !== 32'h108 || wtg[0] !== 32'h200 || wpc[1] !== 32'h10C || wtg[1] !== 32'h300) begin
                fails++;
                $display("FAIL filter_order: got %h/%h then %h/%h, required 108/200 then 10c/300",
                         wpc[0], wtg[0], wpc[1], wtg[1]);
            end
        end
        tests++;
        if (stat_wr_cnt !== 16'd3) begin
            fails++; $display("FAIL filter_cnt: got %0d, required 3", stat_wr_cnt);
        end
        $display("[TB] test_filter done");
    endtask

    task automatic test_flush();
        int busy_n = 0;
        int sw_n = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1 drive_ev(1, 32'h400 + 4*i, 32'h500 + 4*i, 1, 0, 0);
        end
        @(posedge clk); #1;
        drive_ev(1, 32'h40C, 32'h50C, 1, 0, 0);
        flush_req = 1'b1;
        @(negedge clk);
        tests++;
        if (ex_ready !== 1'b0) begin
            fails++; $display("FAIL flush_same_cycle_ready: got %0b, required 0", ex_ready);
        end
        tests++;
        if (btb_update_en !== 1'b1 || btb_pc_update !== 32'h404) begin
            fails++; $display("FAIL flush_prior_write: en=%0b pc=%h, required 1/404", btb_update_en, btb_pc_update);
        end
        @(posedge clk); #1;
        ex_valid = 1'b0; flush_req = 1'b0;
        for (int k = 0; k < 72; k++) begin
            @(negedge clk);
            if (flush_busy) busy_n++;
            if (btb_update_en) begin
                tests++;
                if (btb_pc_update !== 32'(sw_n * 4) || btb_target_update !== 32'h0) begin
                    fails++;
                    $display("FAIL sweep_write%0d: pc=%h tgt=%h, required %h/0",
                             sw_n, btb_pc_update, btb_target_update, sw_n * 4);
                end
                sw_n++;
            end
            @(posedge clk); #1 flush_req = (k == 10);
        end
        flush_req = 1'b0;
        tests++;
        if (sw_n != SIZE) begin
            fails++; $display("FAIL sweep_count: got %0d writes, required %0d", sw_n, SIZE);
        end
        tests++;
        if (busy_n != SIZE) begin
            fails++; $display("FAIL sweep_busy: got %0d busy cycles, required %0d", busy_n, SIZE);
        end
        $display("[TB] test_flush done");
    endtask

    task automatic test_back_to_back();
        int k = 0;
        bit acc;
        bit [31:0] wpc[$];
        bit [31:0] wtg[$];
        @(posedge clk); #1 flush_req = 1'b1;
        @(posedge clk); #1 flush_req = 1'b0;
        for (int c = 0; c < 200 && (k < 6 || c < 90); c++) begin
            if (k < 6) drive_ev(1, 32'h10 + 4*k, 32'h8000 + k, 1, 0, 0);
            else ex_valid = 1'b0;
            @(negedge clk);
            tests++;
            if (ex_ready !== m_ready()) begin
                fails++; $display("FAIL b2b_ready_c%0d: got %0b, required %0b", c, ex_ready, m_ready());
            end
            if (btb_update_en && btb_target_update != 0) begin
                wpc.push_back(btb_pc_update); wtg.push_back(btb_target_update);
            end
            acc = ex_valid && m_ready();
            @(posedge clk); #1;
            if (acc) k++;
        end
        ex_valid = 1'b0;
        tests++;
        if (wpc.size() != 6) begin
            fails++; $display("FAIL b2b_count: got %0d writes, required 6", wpc.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                tests++;
                if (wpc[i] !== 32'h10 + 4*i || wtg[i] !== 32'h8000 + i) begin
                    fails++;
                    $display("FAIL b2b_order%0d: pc=%h tgt=%h, required %h/%h", i, wpc[i], wtg[i],
                             32'h10 + 4*i, 32'h8000 + i);
                end
            end
        end
        $display("[TB] test_back_to_back done");
    endtask

    task automatic test_async_reset();
        @(posedge clk); #1 flush_req = 1'b1;
        @(posedge clk); #1 flush_req = 1'b0;
        repeat (21) @(posedge clk);
        @(negedge clk);
        tests++;
        if (btb_update_en !== 1'b1 || btb_pc_update !== 32'h50 || flush_busy !== 1'b1) begin
            fails++;
            $display("FAIL arst_sync_idx20: en=%0b pc=%h busy=%0b, required 1/50/1",
                     btb_update_en, btb_pc_update, flush_busy);
        end
        #2 rst = 1'b1;
        #1;
        tests++;
        if ({btb_update_en, btb_pc_update, btb_target_update, stat_wr_cnt, flush_busy} !== '0) begin
            fails++;
            $display("FAIL arst_outputs: en=%0b pc=%h tgt=%h cnt=%0d busy=%0b, required all 0",
                     btb_update_en, btb_pc_update, btb_target_update, stat_wr_cnt, flush_busy);
        end
        #3 rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            tests++;
            if (btb_update_en !== 1'b0 || flush_busy !== 1'b0 || ex_ready !== 1'b1) begin
                fails++;
                $display("FAIL arst_after_c%0d: en=%0b busy=%0b ready=%0b, required 0/0/1",
                         c, btb_update_en, flush_busy, ex_ready);
            end
        end
        $display("[TB] test_async_reset done");
    endtask

    task automatic test_random();
        bit last_ready = 1'b1;
        bit [31:0] t;
        for (int c = 0; c < 400; c++) begin
            @(posedge clk); #1;
            if (!(ex_valid && !last_ready)) begin
                t = $urandom;
                drive_ev($urandom_range(0, 9) < 7, $urandom & 32'hFFFF_FFFC, t,
                         $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                         ($urandom_range(0, 1) == 1) ? t : $urandom);
            end
            flush_req = ($urandom_range(0, 119) == 0);
            @(negedge clk);
            tests++;
            if (ex_ready !== m_ready() || btb_update_en !== m_en || flush_busy !== m_sweep ||
                stat_wr_cnt !== m_cnt || (m_en && (btb_pc_update !== m_pc || btb_target_update !== m_tgt))) begin
                fails++;
                $display("FAIL rand_c%0d: ready=%0b en=%0b busy=%0b cnt=%0d pc=%h tgt=%h, required %0b/%0b/%0b/%0d/%h/%h",
                         c, ex_ready, btb_update_en, flush_busy, stat_wr_cnt, btb_pc_update, btb_target_update,
                         m_ready(), m_en, m_sweep, m_cnt, m_pc, m_tgt);
            end
            last_ready = m_ready();
        end
        @(posedge clk); #1;
        ex_valid = 1'b0; flush_req = 1'b0;
        $display("[TB] test_random done");
    endtask

    initial begin
        test_reset();
        test_single();
        test_filter();
        test_flush();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
